// File: rtl/mcdt_rr_arbiter.sv
// mcdt output arbiter: shares the mcdt output port among three show-ahead
// channel FIFOs. Fixed-priority or round-robin arbitration, programmable burst.
module mcdt_rr_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned BW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cfg_rr_en,
    input  logic [BW-1:0] cfg_burst_len,
    input  logic [2:0]    cfg_ch_en,
    input  logic [DW-1:0] ch0_data_i,
    input  logic          ch0_val_i,
    output logic          ch0_req_o,
    input  logic [DW-1:0] ch1_data_i,
    input  logic          ch1_val_i,
    output logic          ch1_req_o,
    input  logic [DW-1:0] ch2_data_i,
    input  logic          ch2_val_i,
    output logic          ch2_req_o,
    output logic [DW-1:0] mcdt_data_o,
    output logic          mcdt_val_o,
    output logic [1:0]    mcdt_id_o,
    output logic          arb_busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    elig_c;
    logic [1:0]    gnt;
    logic [1:0]    rr_ptr;
    logic [BW-1:0] cnt;
    logic [1:0]    winner_c;
    logic          gnt_elig_c;
    logic          pop_c;
    logic [2:0]    req_c;
    logic [DW-1:0] gnt_data_c;
    logic [BW-1:0] burst_eff_c;

    assign elig_c      = {ch2_val_i, ch1_val_i, ch0_val_i} & cfg_ch_en;
    assign burst_eff_c = (cfg_burst_len == '0) ? BW'(1) : cfg_burst_len;
    assign pop_c       = (state == BURST) && gnt_elig_c;

    // Eligibility and head word of the currently granted channel
    always_comb begin
        gnt_elig_c = 1'b0;
        gnt_data_c = '0;
        case (gnt)
            2'd0: begin gnt_elig_c = elig_c[0]; gnt_data_c = ch0_data_i; end
            2'd1: begin gnt_elig_c = elig_c[1]; gnt_data_c = ch1_data_i; end
            2'd2: begin gnt_elig_c = elig_c[2]; gnt_data_c = ch2_data_i; end
            default: begin gnt_elig_c = 1'b0; gnt_data_c = '0; end
        endcase
    end

    // Winner: lowest eligible index, or first eligible from rr_ptr onward
    always_comb begin
        winner_c = 2'd0;
        if (!cfg_rr_en) begin
            if (elig_c[0])      winner_c = 2'd0;
            else if (elig_c[1]) winner_c = 2'd1;
            else                winner_c = 2'd2;
        end else begin
            case (rr_ptr)
                2'd1: begin
                    if (elig_c[1])      winner_c = 2'd1;
                    else if (elig_c[2]) winner_c = 2'd2;
                    else                winner_c = 2'd0;
                end
                2'd2: begin
                    if (elig_c[2])      winner_c = 2'd2;
                    else if (elig_c[0]) winner_c = 2'd0;
                    else                winner_c = 2'd1;
                end
                default: begin
                    if (elig_c[0])      winner_c = 2'd0;
                    else if (elig_c[1]) winner_c = 2'd1;
                    else                winner_c = 2'd2;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: arbitrate in IDLE, leave BURST on last pop or lost eligibility
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (|elig_c) state_nxt = BURST;
            BURST: if (!gnt_elig_c || (cnt == BW'(1))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop strobes: only the granted channel, only while it stays eligible
    always_comb begin
        req_c = 3'b000;
        if (pop_c) begin
            case (gnt)
                2'd0:    req_c = 3'b001;
                2'd1:    req_c = 3'b010;
                2'd2:    req_c = 3'b100;
                default: req_c = 3'b000;
            endcase
        end
    end

    assign ch0_req_o  = req_c[0];
    assign ch1_req_o  = req_c[1];
    assign ch2_req_o  = req_c[2];
    assign arb_busy_o = (state == BURST);

    // Grant, beat counter and round-robin pointer
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            gnt    <= 2'd0;
            cnt    <= '0;
            rr_ptr <= 2'd0;
        end else begin
            if ((state == IDLE) && (|elig_c)) begin
                gnt <= winner_c;
                cnt <= burst_eff_c;
            end else if (pop_c) begin
                cnt <= cnt - BW'(1);
            end
            if ((state == BURST) && (state_nxt == IDLE)) begin
                rr_ptr <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
            end
        end
    end

    // Output register: one beat per pop, data zeroed and id held otherwise
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mcdt_val_o  <= 1'b0;
            mcdt_data_o <= '0;
            mcdt_id_o   <= 2'd0;
        end else begin
            mcdt_val_o  <= pop_c;
            mcdt_data_o <= pop_c ? gnt_data_c : '0;
            if (pop_c) mcdt_id_o <= gnt;
        end
    end

endmodule

// File: doc/mcdt_rr_arbiter.md
Name: mcdt_rr_arbiter

Overview:
Output arbiter for the multi-channel data transfer (mcdt) datapath. It shares the single mcdt output port among the three per-channel slave FIFOs. It selects one non-empty, enabled channel per grant, pops up to a programmable burst of words from it, and drives registered mcdt_data_o/mcdt_val_o/mcdt_id_o. Fixed-priority or round-robin arbitration is selected by configuration.

Parameters:
DW, 32, data width of channel words and output data
BW, 4, width of burst length configuration

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-high (rstn=1 resets)
cfg_rr_en  in  1  1=round-robin, 0=fixed priority ch0>ch1>ch2
cfg_burst_len  in  BW  max words popped per grant; 0 treated as 1
cfg_ch_en  in  3  per-channel enable, bit N = channel N
ch0_data_i  in  DW  ch0 FIFO head word (show-ahead, valid when ch0_val_i=1)
ch0_val_i  in  1  ch0 FIFO not empty
ch0_req_o  out  1  ch0 pop strobe
ch1_data_i / ch1_val_i / ch1_req_o  same as ch0
ch2_data_i / ch2_val_i / ch2_req_o  same as ch0
mcdt_data_o  out  DW  output word
mcdt_val_o  out  1  output word valid, single-cycle per word
mcdt_id_o  out  2  source channel of mcdt_data_o
arb_busy_o  out  1  1 while state=BURST

Behaviour:
- Reset (rstn=1, async): state=IDLE; gnt=0; rr_ptr=0; beat counter=0; mcdt_data_o=0; mcdt_val_o=0; mcdt_id_o=0; all chN_req_o=0; arb_busy_o=0. Reset asserted mid-burst aborts the burst immediately; no pop is issued in reset.
- Eligible channel N: chN_val_i=1 and cfg_ch_en[N]=1.
- FSM IDLE: if any channel is eligible, pick the winner, latch gnt=winner and cnt=max(cfg_burst_len,1), then go to BURST. Otherwise stay in IDLE. No pop is issued in IDLE, so every grant costs one bubble cycle.
- Winner selection, fixed mode: lowest eligible index.
- Winner selection, RR mode: first eligible in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- cfg_rr_en and cfg_burst_len are sampled only in IDLE. Changing them mid-burst has no effect until the next arbitration.
- FSM BURST: chgnt_req_o = chgnt_val_i & cfg_ch_en[gnt] (combinational). Non-granted req outputs stay 0. At most one req_o is high in any cycle.
- On each pop: cnt decrements.
- Output register: one cycle after a pop, mcdt_val_o=1, mcdt_data_o=popped word, mcdt_id_o=gnt.
- Cycles without a pop: mcdt_val_o=0 and mcdt_data_o=0. mcdt_id_o holds its last value.
- Burst end conditions, any of:
  (a) pop with cnt==1;
  (b) granted channel not eligible in BURST (FIFO empty or disabled), which ends the burst with no pop that cycle.
- On burst end: next state IDLE; rr_ptr=(gnt+1) mod 3. rr_ptr updates in both modes but is used only in RR mode.
- Latency: chN_val_i rises with the arbiter in IDLE at cycle 0 → req_o at cycle 1 → mcdt_val_o at cycle 2.
- Peak throughput: burst_len words per burst_len+1 cycles.
- Word order within a channel is preserved. No word is dropped or duplicated; exactly one output beat occurs per pop.
- cnt width is BW; the maximum burst is 2^BW-1.

Test Plan:
- Reset: assert rstn=1 during cycle 2 of a 4-beat ch1 burst → all outputs 0 in the same cycle. After release with all FIFOs empty → no mcdt_val_o.
- Single channel: ch0 preloaded with 'h00C0_0000..'h00C0_0009, burst_len=4, RR → mcdt_val_o groups of 4, 4, 2 with a one-cycle gap between groups, id=0, data in order; first valid exactly 2 cycles after ch0_val_i rises.
- RR fairness: ch0/ch1/ch2 each preloaded with 10 words ('h00C0_xxxx, 'h00C1_xxxx, 'h00C2_xxxx), burst_len=1 → ids 0,1,2,0,1,2… alternating valid and bubble; 30 words out; each channel's data in order.
- Fixed priority: same preload, cfg_rr_en=0, burst_len=2 → all 10 ch0 words first, then ch1, then ch2.
- Early release: ch1 holds 2 words and ch2 holds 4, burst_len=4, RR with rr_ptr=1 → 2 ch1 beats, burst ends, next grant ch2 with 4 beats.
- Enable mask and zero burst: cfg_ch_en=3'b101, burst_len=0, all valid → ch1_req_o never asserts; ids alternate 0,2 one word per grant.
